// File: rtl/pipeline_ctrl_if.sv
// Control bundle between the pipeline datapath (master) and the hazard/stall controller (slave).
// The datapath reports hit/hazard status; the controller returns latch enables, flushes and status.
interface pipeline_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             ihit;
    logic             dhit;
    logic             mem_dREN;
    logic             mem_dWEN;
    logic             ex_dREN;
    logic [4:0]       ex_regDst;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             branch_taken;
    logic             mem_halt;

    logic             pc_en;
    logic             ifid_en;
    logic             idex_en;
    logic             exmem_en;
    logic             memwb_en;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             halt;
    logic [1:0]       state;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_regDst, id_rs, id_rt,
               branch_taken, mem_halt,
        input  pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               exmem_flush, halt, state, stall_cnt, flush_cnt
    );

    modport slave (
        input  ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_regDst, id_rs, id_rt,
               branch_taken, mem_halt,
        output pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush,
               exmem_flush, halt, state, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline hazard controller: data-miss freeze, halt drain, branch flush,
// load-use stall and fetch-miss bubble, with saturating stall/flush counters.
module pipeline_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic          CLK,
    input  logic          nRST,
    pipeline_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DWAIT  = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] stall_q;
    logic [CNT_W-1:0] flush_q;

    logic dmiss;
    logic luse;
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic memwb_en;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic stall_inc;
    logic flush_inc;

    assign dmiss = (bus.mem_dREN | bus.mem_dWEN) & ~bus.dhit;
    assign luse  = bus.ex_dREN & (bus.ex_regDst != 5'd0) &
                   ((bus.ex_regDst == bus.id_rs) | (bus.ex_regDst == bus.id_rt));

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // DWAIT evaluates the same priority chain as RUN; it only records that a miss is pending.
    always_comb begin
        state_d     = state_q;
        pc_en       = bus.ihit;
        ifid_en     = 1'b1;
        idex_en     = 1'b1;
        exmem_en    = 1'b1;
        memwb_en    = 1'b1;
        ifid_flush  = 1'b0;
        idex_flush  = 1'b0;
        exmem_flush = 1'b0;
        flush_inc   = 1'b0;
        case (state_q)
            RUN, DWAIT: begin
                state_d = RUN;
                if (dmiss) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_en  = 1'b0;
                    exmem_en = 1'b0;
                    memwb_en = 1'b0;
                    state_d  = DWAIT;
                end else if (bus.mem_halt) begin
                    pc_en       = 1'b0;
                    ifid_flush  = 1'b1;
                    idex_flush  = 1'b1;
                    exmem_flush = 1'b1;
                    state_d     = DRAIN;
                end else if (bus.branch_taken) begin
                    pc_en      = 1'b1;
                    ifid_flush = 1'b1;
                    idex_flush = 1'b1;
                    flush_inc  = 1'b1;
                end else if (luse) begin
                    pc_en      = 1'b0;
                    ifid_en    = 1'b0;
                    idex_flush = 1'b1;
                end else if (!bus.ihit) begin
                    pc_en      = 1'b0;
                    ifid_flush = 1'b1;
                end
            end
            DRAIN: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                state_d  = HALTED;
            end
            default: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
                state_d  = HALTED;
            end
        endcase
    end

    assign stall_inc = ((state_q == RUN) || (state_q == DWAIT)) && !pc_en && !bus.mem_halt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (stall_inc && (stall_q != '1)) begin
                stall_q <= stall_q + 1'b1;
            end
            if (flush_inc && (flush_q != '1)) begin
                flush_q <= flush_q + 1'b1;
            end
        end
    end

    assign bus.pc_en       = pc_en;
    assign bus.ifid_en     = ifid_en;
    assign bus.idex_en     = idex_en;
    assign bus.exmem_en    = exmem_en;
    assign bus.memwb_en    = memwb_en;
    assign bus.ifid_flush  = ifid_flush;
    assign bus.idex_flush  = idex_flush;
    assign bus.exmem_flush = exmem_flush;
    assign bus.halt        = (state_q == HALTED);
    assign bus.state       = state_q;
    assign bus.stall_cnt   = stall_q;
    assign bus.flush_cnt   = flush_q;
endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: one task per scenario with hand-computed expectations.
// Control outputs are packed as {pc_en, ifid/idex/exmem/memwb_en, ifid/idex/exmem_flush, halt}.
module tb_pipeline_ctrl;
    localparam int CNT_W = 8;

    localparam logic [8:0] C_IDLE   = 9'b1_1111_000_0;
    localparam logic [8:0] C_FREEZE = 9'b0_0000_000_0;
    localparam logic [8:0] C_LUSE   = 9'b0_0111_010_0;
    localparam logic [8:0] C_BRANCH = 9'b1_1111_110_0;
    localparam logic [8:0] C_IMISS  = 9'b0_1111_100_0;
    localparam logic [8:0] C_MHALT  = 9'b0_1111_111_0;
    localparam logic [8:0] C_DRAIN  = 9'b0_0001_000_0;
    localparam logic [8:0] C_HALTED = 9'b0_0000_000_1;

    logic clk;
    logic nrst;
    int   total;
    int   bad;
    logic [8:0] ctl;

    pipeline_ctrl_if #(.CNT_W(CNT_W)) bus ();

    pipeline_ctrl #(.CNT_W(CNT_W)) dut (
        .CLK  (clk),
        .nRST (nrst),
        .bus  (bus)
    );

    assign ctl = {bus.pc_en, bus.ifid_en, bus.idex_en, bus.exmem_en, bus.memwb_en,
                  bus.ifid_flush, bus.idex_flush, bus.exmem_flush, bus.halt};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // driver tasks
    task automatic set_idle();
        bus.ihit         = 1'b1;
        bus.dhit         = 1'b0;
        bus.mem_dREN     = 1'b0;
        bus.mem_dWEN     = 1'b0;
        bus.ex_dREN      = 1'b0;
        bus.ex_regDst    = 5'd0;
        bus.id_rs        = 5'd0;
        bus.id_rt        = 5'd0;
        bus.branch_taken = 1'b0;
        bus.mem_halt     = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        set_idle();
        nrst = 1'b0;
        tick();
        nrst = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        set_idle();
        nrst = 1'b0;
        #1;
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL reset_state got=%0d exp=0", bus.state); end
        total++; if (bus.stall_cnt !== 8'd0) begin bad++; $display("FAIL reset_stall got=%0d exp=0", bus.stall_cnt); end
        total++; if (bus.flush_cnt !== 8'd0) begin bad++; $display("FAIL reset_flush got=%0d exp=0", bus.flush_cnt); end
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL reset_ctl got=%b exp=%b", ctl, C_IDLE); end
        tick();
        nrst = 1'b1;
        #1;
        // release mid-cycle: nothing changes until the next edge
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL release_state got=%0d exp=0", bus.state); end
        tick();
        total++; if (bus.stall_cnt !== 8'd0) begin bad++; $display("FAIL idle_stall got=%0d exp=0", bus.stall_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        bus.ex_dREN = 1'b1; bus.ex_regDst = 5'd5; bus.id_rs = 5'd5; bus.id_rt = 5'd2;
        #1;
        total++; if (ctl !== C_LUSE) begin bad++; $display("FAIL luse_rs_ctl got=%b exp=%b", ctl, C_LUSE); end
        tick();
        total++; if (bus.stall_cnt !== 8'd1) begin bad++; $display("FAIL luse_rs_stall got=%0d exp=1", bus.stall_cnt); end
        bus.ex_regDst = 5'd7; bus.id_rs = 5'd3; bus.id_rt = 5'd7;
        #1;
        total++; if (ctl !== C_LUSE) begin bad++; $display("FAIL luse_rt_ctl got=%b exp=%b", ctl, C_LUSE); end
        tick();
        total++; if (bus.stall_cnt !== 8'd2) begin bad++; $display("FAIL luse_rt_stall got=%0d exp=2", bus.stall_cnt); end
        bus.ex_regDst = 5'd0; bus.id_rs = 5'd0; bus.id_rt = 5'd0;
        #1;
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL luse_r0_ctl got=%b exp=%b", ctl, C_IDLE); end
        tick();
        total++; if (bus.stall_cnt !== 8'd2) begin bad++; $display("FAIL luse_r0_stall got=%0d exp=2", bus.stall_cnt); end
        bus.ex_regDst = 5'd9; bus.id_rs = 5'd4; bus.id_rt = 5'd6;
        #1;
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL luse_nomatch_ctl got=%b exp=%b", ctl, C_IDLE); end
    endtask

    task automatic test_dmiss();
        do_reset();
        bus.mem_dREN = 1'b1; bus.dhit = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (ctl !== C_FREEZE) begin bad++; $display("FAIL dmiss_ctl cyc=%0d got=%b exp=%b", i, ctl, C_FREEZE); end
            tick();
            total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL dmiss_state cyc=%0d got=%0d exp=1", i, bus.state); end
        end
        bus.dhit = 1'b1;
        #1;
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL dhit_ctl got=%b exp=%b", ctl, C_IDLE); end
        tick();
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL dhit_state got=%0d exp=0", bus.state); end
        total++; if (bus.stall_cnt !== 8'd3) begin bad++; $display("FAIL dmiss_stall got=%0d exp=3", bus.stall_cnt); end
        bus.mem_dREN = 1'b0; bus.mem_dWEN = 1'b1; bus.dhit = 1'b0;
        #1;
        total++; if (ctl !== C_FREEZE) begin bad++; $display("FAIL store_miss_ctl got=%b exp=%b", ctl, C_FREEZE); end
    endtask

    task automatic test_branch();
        do_reset();
        bus.branch_taken = 1'b1; bus.ihit = 1'b0;
        bus.ex_dREN = 1'b1; bus.ex_regDst = 5'd4; bus.id_rs = 5'd4;
        #1;
        total++; if (ctl !== C_BRANCH) begin bad++; $display("FAIL branch_ctl got=%b exp=%b", ctl, C_BRANCH); end
        tick();
        total++; if (bus.flush_cnt !== 8'd1) begin bad++; $display("FAIL branch_flush got=%0d exp=1", bus.flush_cnt); end
        total++; if (bus.stall_cnt !== 8'd0) begin bad++; $display("FAIL branch_stall got=%0d exp=0", bus.stall_cnt); end
        set_idle();
        bus.ihit = 1'b0;
        #1;
        total++; if (ctl !== C_IMISS) begin bad++; $display("FAIL imiss_ctl got=%b exp=%b", ctl, C_IMISS); end
        tick();
        total++; if (bus.stall_cnt !== 8'd1) begin bad++; $display("FAIL imiss_stall got=%0d exp=1", bus.stall_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.mem_dREN = 1'b1; bus.dhit = 1'b0; bus.branch_taken = 1'b1;
        #1;
        total++; if (ctl !== C_FREEZE) begin bad++; $display("FAIL miss_branch_ctl got=%b exp=%b", ctl, C_FREEZE); end
        tick();
        total++; if (bus.flush_cnt !== 8'd0) begin bad++; $display("FAIL miss_branch_flush got=%0d exp=0", bus.flush_cnt); end
        bus.dhit = 1'b1;
        #1;
        total++; if (ctl !== C_BRANCH) begin bad++; $display("FAIL deferred_branch_ctl got=%b exp=%b", ctl, C_BRANCH); end
        tick();
        total++; if (bus.flush_cnt !== 8'd1) begin bad++; $display("FAIL deferred_branch_flush got=%0d exp=1", bus.flush_cnt); end
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL deferred_branch_state got=%0d exp=0", bus.state); end
        total++; if (bus.stall_cnt !== 8'd1) begin bad++; $display("FAIL deferred_branch_stall got=%0d exp=1", bus.stall_cnt); end
    endtask

    task automatic test_halt();
        do_reset();
        bus.mem_halt = 1'b1;
        #1;
        total++; if (ctl !== C_MHALT) begin bad++; $display("FAIL mem_halt_ctl got=%b exp=%b", ctl, C_MHALT); end
        tick();
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL drain_state got=%0d exp=2", bus.state); end
        bus.mem_halt = 1'b0;
        #1;
        total++; if (ctl !== C_DRAIN) begin bad++; $display("FAIL drain_ctl got=%b exp=%b", ctl, C_DRAIN); end
        tick();
        total++; if (bus.state !== 2'd3) begin bad++; $display("FAIL halted_state got=%0d exp=3", bus.state); end
        for (int i = 0; i < 4; i++) begin
            bus.ihit = i[0]; bus.branch_taken = ~i[0]; bus.mem_dREN = i[1];
            #1;
            total++; if (ctl !== C_HALTED) begin bad++; $display("FAIL halted_ctl cyc=%0d got=%b exp=%b", i, ctl, C_HALTED); end
            tick();
        end
        total++; if (bus.state !== 2'd3) begin bad++; $display("FAIL halted_hold got=%0d exp=3", bus.state); end
        total++; if (bus.flush_cnt !== 8'd0) begin bad++; $display("FAIL halted_flush got=%0d exp=0", bus.flush_cnt); end
        total++; if (bus.stall_cnt !== 8'd0) begin bad++; $display("FAIL halted_stall got=%0d exp=0", bus.stall_cnt); end
    endtask

    task automatic test_saturate();
        do_reset();
        bus.ihit = 1'b0;
        for (int i = 0; i < 255; i++) tick();
        total++; if (bus.stall_cnt !== 8'hFF) begin bad++; $display("FAIL sat_reach got=%0d exp=255", bus.stall_cnt); end
        for (int i = 0; i < 6; i++) tick();
        total++; if (bus.stall_cnt !== 8'hFF) begin bad++; $display("FAIL sat_hold got=%0d exp=255", bus.stall_cnt); end
    endtask

    task automatic test_async_reset();
        do_reset();
        bus.mem_dREN = 1'b1; bus.dhit = 1'b0;
        tick();
        tick();
        total++; if (bus.state !== 2'd1) begin bad++; $display("FAIL pre_reset_state got=%0d exp=1", bus.state); end
        #2;
        set_idle();
        nrst = 1'b0;
        #1;
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL dwait_reset_state got=%0d exp=0", bus.state); end
        total++; if (bus.stall_cnt !== 8'd0) begin bad++; $display("FAIL dwait_reset_stall got=%0d exp=0", bus.stall_cnt); end
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL dwait_reset_ctl got=%b exp=%b", ctl, C_IDLE); end
        tick();
        nrst = 1'b1;
        bus.mem_halt = 1'b1;
        tick();
        total++; if (bus.state !== 2'd2) begin bad++; $display("FAIL pre_reset_drain got=%0d exp=2", bus.state); end
        #3;
        set_idle();
        nrst = 1'b0;
        #1;
        total++; if (bus.state !== 2'd0) begin bad++; $display("FAIL drain_reset_state got=%0d exp=0", bus.state); end
        total++; if (ctl !== C_IDLE) begin bad++; $display("FAIL drain_reset_ctl got=%b exp=%b", ctl, C_IDLE); end
        tick();
        nrst = 1'b1;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nrst  = 1'b1;
        set_idle();
        test_reset();
        test_load_use();
        test_dmiss();
        test_branch();
        test_back_to_back();
        test_halt();
        test_saturate();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pipeline_ctrl.md
PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, width of both saturating performance counters.
REQ-002 CLK  in  1  system clock; all state updates on rising edge.
REQ-003 nRST  in  1  asynchronous, active-low reset.
REQ-004 ihit  in  1  instruction fetch complete this cycle.
REQ-005 dhit  in  1  data access complete this cycle.
REQ-006 mem_dREN, mem_dWEN  in  1 each  load/store currently in MEM stage.
REQ-007 ex_dREN  in  1  load currently in EX stage.
REQ-008 ex_regDst  in  5  destination register (regbits_t) of EX-stage instruction.
REQ-009 id_rs, id_rt  in  5 each  source registers of ID-stage instruction.
REQ-010 branch_taken  in  1  branch/jump resolved taken in EX.
REQ-011 mem_halt  in  1  halt instruction in MEM stage.
REQ-012 pc_en  out  1  PC register load enable.
REQ-013 ifid_en, idex_en, exmem_en, memwb_en  out  1 each  pipeline latch enables.
REQ-014 ifid_flush, idex_flush, exmem_flush  out  1 each  latch loads bubble (all-zero) when enabled.
REQ-015 halt  out  1  processor halted.
REQ-016 state  out  2  current FSM state encoding (RUN=0, DWAIT=1, DRAIN=2, HALTED=3).
REQ-017 stall_cnt, flush_cnt  out  CNT_W each  performance counters.

Function
REQ-018 FSM states RUN, DWAIT, DRAIN, HALTED; registered; all control outputs combinational from state and inputs.
REQ-019 dmiss = (mem_dREN | mem_dWEN) & ~dhit; luse = ex_dREN & (ex_regDst != 0) & (ex_regDst == id_rs | ex_regDst == id_rt).
REQ-020 Default (no condition): all enables 1, all flushes 0, pc_en = ihit.
REQ-021 RUN/DWAIT priority, highest first: dmiss > mem_halt > branch_taken > luse > ~ihit.
REQ-022 dmiss: pc_en and all four enables 0, all flushes 0 (full freeze); next state DWAIT.
REQ-023 DWAIT with dhit: default outputs, remaining lower-priority rules apply; next state RUN (or DRAIN if mem_halt).
REQ-024 mem_halt (no dmiss): pc_en 0, ifid_flush=idex_flush=exmem_flush=1, memwb_en 1; next state DRAIN.
REQ-025 branch_taken: pc_en 1 regardless of ihit; ifid_flush=idex_flush=1; flush_cnt increments.
REQ-026 luse: pc_en 0, ifid_en 0, idex_flush 1, exmem_en=memwb_en=1.
REQ-027 ~ihit only: pc_en 0, ifid_flush 1, later stages advance.
REQ-028 DRAIN: exactly one cycle; pc_en and ifid/idex/exmem enables 0, memwb_en 1; next state HALTED.
REQ-029 HALTED: halt 1; all enables 0, flushes 0; state held until reset; inputs ignored.
REQ-030 stall_cnt increments each RUN/DWAIT cycle with pc_en=0 and no mem_halt; both counters saturate at all-ones, never wrap.
REQ-031 Simultaneous dmiss and branch_taken: freeze wins; branch flush and flush_cnt increment deferred to the dhit cycle (branch_taken held by frozen EX latch).
REQ-032 luse with register 0 never stalls.

Reset
REQ-033 nRST low asynchronously forces state RUN, stall_cnt=0, flush_cnt=0, halt=0, independent of CLK.
REQ-034 Reset mid-DWAIT or mid-DRAIN returns to RUN; outputs take RUN values from that instant.
REQ-035 Release of nRST takes effect on the first rising CLK edge after deassertion.

Verification
REQ-036 Load r5 in EX, id_rs=5, ihit=1 -> pc_en=0, ifid_en=0, idex_flush=1, stall_cnt +1; ex_regDst=0 -> no stall.
REQ-037 mem_dREN=1, dhit=0 for 3 cycles then dhit=1 -> 3 cycles all enables 0, state DWAIT, then RUN, stall_cnt +3.
REQ-038 branch_taken=1, ihit=0 -> pc_en=1, ifid_flush=idex_flush=1, flush_cnt +1.
REQ-039 mem_halt=1 -> DRAIN one cycle with memwb_en=1, then HALTED, halt=1; later ihit/branch_taken toggling changes nothing.
REQ-040 Force 2^CNT_W+5 stall cycles -> stall_cnt holds at all-ones.
REQ-041 Assert nRST low during DWAIT between clock edges -> state RUN, counters 0 immediately.
